mux_arb_nto1: RTL and testbench

Parametrised N-to-1, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes. It generalises the datapath 2:1 selector to any channel count and width, adds a round-robin arbitration mode, and registers its output. It sits between producers such as the ALU, load unit and CSR read path and a shared consumer such as the write-back port, with one register stage of latency and full throughput.

---
 rtl/mux_arb_nto1.sv | 107 ++++++++++
 tb/tb_mux_arb_nto1.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_nto1.sv
`default_nettype none
// ============================================================================
// mux_arb_nto1 : N-to-1 registered mux, valid/ready, explicit-select or RR grant
// Rev 1.0
// ============================================================================
module mux_arb_nto1 #(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  parameter  int RR    = 0,
  localparam int SELW  = (N > 2) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src
);

  localparam int              c_padw = 1 << SELW;
  localparam logic [SELW-1:0] c_last = SELW'(N - 1);

  logic [c_padw-1:0] w_valid_pad;
  logic              w_load;
  logic              w_gnt_vld;
  logic              w_xfer;
  logic [SELW-1:0]   w_gnt;
  logic [SELW-1:0]   w_idx;
  logic [WIDTH-1:0]  w_data;

  logic              r_valid;
  logic [WIDTH-1:0]  r_data;
  logic [SELW-1:0]   r_src;
  logic [SELW-1:0]   r_ptr;

  // Zero-padding lets an out-of-range select index a defined bit.
  assign w_valid_pad = c_padw'(in_valid);
  assign w_load      = !r_valid || out_ready;
  assign w_xfer      = rst_n && w_gnt_vld && w_load;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = '0;
    if (RR != 0) begin
      for (int k = 0; k < N; k++) begin
        w_idx = (int'(r_ptr) + k >= N) ? SELW'(int'(r_ptr) + k - N)
                                       : SELW'(int'(r_ptr) + k);
        if (!w_gnt_vld && w_valid_pad[w_idx]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = w_idx;
        end
      end
    end else if (int'(sel) < N) begin
      w_gnt_vld = w_valid_pad[sel];
      w_gnt     = sel;
    end
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt == SELW'(i)) begin
        w_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign in_ready[gi] = w_xfer && (w_gnt == SELW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
    end else if (w_load) begin
      r_valid <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_data <= w_data;
        r_src  <= w_gnt;
      end
    end
  end

  // Pointer moves past the winner; explicit wrap keeps it below N.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if ((RR != 0) && w_xfer) begin
      r_ptr <= (w_gnt == c_last) ? '0 : w_gnt + 1'b1;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_src   = r_src;

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_nto1.sv
`default_nettype none
// ============================================================================
// tb_mux_arb_nto1 : directed bench for four configurations of mux_arb_nto1
// Rev 1.0
// ============================================================================
module tb_mux_arb_nto1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // u0: RR=0, N=4, WIDTH=32
  logic [3:0]   valid0, ready0;
  logic [127:0] data0;
  logic [1:0]   sel0, os0;
  logic         ov0, or0;
  logic [31:0]  od0;
  // u1: RR=0, N=5, WIDTH=8
  logic [4:0]   valid1, ready1;
  logic [39:0]  data1;
  logic [2:0]   sel1, os1;
  logic         ov1, or1;
  logic [7:0]   od1;
  // u2: RR=1, N=4, WIDTH=8
  logic [3:0]   valid2, ready2;
  logic [31:0]  data2;
  logic [1:0]   sel2, os2;
  logic         ov2, or2;
  logic [7:0]   od2;
  // u3: RR=1, N=3, WIDTH=8
  logic [2:0]   valid3, ready3;
  logic [23:0]  data3;
  logic [1:0]   sel3, os3;
  logic         ov3, or3;
  logic [7:0]   od3;

  mux_arb_nto1 #(.WIDTH(32), .N(4), .RR(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid0), .in_ready(ready0), .in_data(data0),
    .sel(sel0), .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_src(os0));
  mux_arb_nto1 #(.WIDTH(8), .N(5), .RR(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid1), .in_ready(ready1), .in_data(data1),
    .sel(sel1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_src(os1));
  mux_arb_nto1 #(.WIDTH(8), .N(4), .RR(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid2), .in_ready(ready2), .in_data(data2),
    .sel(sel2), .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_src(os2));
  mux_arb_nto1 #(.WIDTH(8), .N(3), .RR(1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid3), .in_ready(ready3), .in_data(data3),
    .sel(sel3), .out_valid(ov3), .out_ready(or3), .out_data(od3), .out_src(os3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_alt[4];
    int exp_wrap[4];
    int exp_ptr3[4];
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    valid0 = '0; data0 = '0; sel0 = '0; or0 = 1'b1;
    valid1 = '0; data1 = '0; sel1 = '0; or1 = 1'b1;
    valid2 = '0; data2 = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; sel2 = '0; or2 = 1'b1;
    valid3 = '0; data3 = {8'hC2, 8'hC1, 8'hC0};        sel3 = '0; or3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Load a word so reset has something to discard
    rst_n = 1'b1;
    valid0 = 4'b0001; sel0 = 2'd0; data0[31:0] = 32'h0000_0055;
    tick();
    chk("pre_rst_valid", 64'(ov0), 64'd1);
    chk("pre_rst_data", 64'(od0), 64'h55);

    rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(ov0), 64'd0);
    chk("rst_data", 64'(od0), 64'd0);
    chk("rst_src", 64'(os0), 64'd0);
    chk("rst_ptr", 64'(u0.r_ptr), 64'd0);
    chk("rst_ready", 64'(ready0), 64'd0);

    // Basic select after release
    sel0 = 2'd2; valid0 = 4'b0100; data0[64 +: 32] = 32'hDEAD_BEEF; or0 = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("sel2_ready", 64'(ready0), 64'b0100);
    tick();
    chk("sel2_valid", 64'(ov0), 64'd1);
    chk("sel2_data", 64'(od0), 64'hDEAD_BEEF);
    chk("sel2_src", 64'(os0), 64'd2);

    // Unselected request ignored
    sel0 = 2'd1; valid0 = 4'b0001;
    #1;
    chk("unsel_ready", 64'(ready0), 64'd0);
    tick();
    chk("unsel_valid", 64'(ov0), 64'd0);
    chk("unsel_data_hold", 64'(od0), 64'hDEAD_BEEF);
    chk("unsel_src_hold", 64'(os0), 64'd2);

    // N=5: highest legal select, then out-of-range select
    sel1 = 3'd4; valid1 = 5'b10000; data1[32 +: 8] = 8'hA4;
    #1;
    chk("n5_sel4_ready", 64'(ready1), 64'b10000);
    tick();
    chk("n5_sel4_data", 64'(od1), 64'hA4);
    chk("n5_sel4_src", 64'(os1), 64'd4);
    chk("n5_sel4_valid", 64'(ov1), 64'd1);
    sel1 = 3'd5; valid1 = 5'b11111;
    #1;
    chk("n5_sel5_ready", 64'(ready1), 64'd0);
    tick();
    chk("n5_sel5_valid", 64'(ov1), 64'd0);
    valid1 = '0;

    // Backpressure
    sel0 = 2'd0; valid0 = 4'b0001; data0[31:0] = 32'h11;
    tick();
    chk("bp_first_data", 64'(od0), 64'h11);
    or0 = 1'b0; sel0 = 2'd1; valid0 = 4'b0010; data0[32 +: 32] = 32'h22;
    #1;
    chk("bp_stall_ready", 64'(ready0), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_data", 64'(od0), 64'h11);
      chk("bp_hold_src", 64'(os0), 64'd0);
      chk("bp_hold_valid", 64'(ov0), 64'd1);
    end
    or0 = 1'b1;
    #1;
    chk("bp_release_ready", 64'(ready0), 64'b0010);
    tick();
    chk("bp_second_data", 64'(od0), 64'h22);
    chk("bp_second_src", 64'(os0), 64'd1);
    chk("bp_second_valid", 64'(ov0), 64'd1);
    valid0 = '0;

    // Round robin, all valid
    valid2 = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_all_src", 64'(os2), 64'(i % 4));
      chk("rr_all_data", 64'(od2), 64'(8'hA0 + 8'(i % 4)));
    end
    chk("rr_all_ptr", 64'(u2.r_ptr), 64'd0);

    // Round robin, sparse
    exp_alt = '{1, 3, 1, 3};
    valid2 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_sparse_src", 64'(os2), 64'(exp_alt[i]));
    end
    valid2 = '0;

    // N=3 wrap: prime ptr to 2, then channels 2 and 0
    valid3 = 3'b010;
    tick();
    chk("n3_prime_src", 64'(os3), 64'd1);
    chk("n3_prime_ptr", 64'(u3.r_ptr), 64'd2);
    exp_wrap = '{2, 0, 2, 0};
    exp_ptr3 = '{0, 1, 0, 1};
    valid3 = 3'b101;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("n3_wrap_src", 64'(os3), 64'(exp_wrap[i]));
      chk("n3_wrap_ptr", 64'(u3.r_ptr), 64'(exp_ptr3[i]));
    end
    valid3 = '0;

    // Reset mid-operation with ptr = 2
    valid2 = 4'b0010;
    tick();
    chk("mid_pre_ptr", 64'(u2.r_ptr), 64'd2);
    chk("mid_pre_valid", 64'(ov2), 64'd1);
    valid2 = 4'b1111; or2 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(ov2), 64'd0);
    chk("mid_rst_ptr", 64'(u2.r_ptr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; or2 = 1'b1;
    tick();
    chk("mid_post_src", 64'(os2), 64'd0);
    chk("mid_post_valid", 64'(ov2), 64'd1);
    chk("mid_post_data", 64'(od2), 64'hA0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
